// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared BCD digit types, limits and time-of-day helpers
package time_keeper_pkg;
  localparam int DIG_W = 4;
  typedef logic [DIG_W-1:0] digit_t;
  localparam digit_t MAX_MIN_TENS = 4'd5;
  localparam digit_t MAX_HOUR_TENS = 4'd2;
  localparam digit_t MAX_HOUR_UNITS_AT_2 = 4'd3;
  localparam digit_t DIG_RST = 4'd0;
  localparam digit_t DIG_MAX = 4'd9;
  typedef struct packed {
    digit_t h1;
    digit_t h0;
    digit_t m1;
    digit_t m0;
  } hhmm_t;
  function automatic logic load_ok(hhmm_t t);
    return t.m0 <= DIG_MAX && t.m1 <= MAX_MIN_TENS && t.h0 <= DIG_MAX && t.h1 <= MAX_HOUR_TENS
      && (t.h1 < MAX_HOUR_TENS || t.h0 <= MAX_HOUR_UNITS_AT_2);
  endfunction
  function automatic hhmm_t bcd_inc(hhmm_t t);
    hhmm_t n;
    logic hour_wrap;
    n = t;
    hour_wrap = t.h1 == MAX_HOUR_TENS && t.h0 == MAX_HOUR_UNITS_AT_2;
    n.m0 = t.m0 == DIG_MAX ? DIG_RST : t.m0 + 4'd1;
    if (t.m0 == DIG_MAX) begin
      n.m1 = t.m1 == MAX_MIN_TENS ? DIG_RST : t.m1 + 4'd1;
      if (t.m1 == MAX_MIN_TENS) begin
        n.h0 = hour_wrap || t.h0 == DIG_MAX ? DIG_RST : t.h0 + 4'd1;
        n.h1 = hour_wrap ? DIG_RST : t.h0 == DIG_MAX ? t.h1 + 4'd1 : t.h1;
      end
    end
    return n;
  endfunction
endpackage

// File: rtl/time_keeper_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV; tick flags the wrapping cycle combinationally
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_,
  input  logic EN,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = EN && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset_ || clr) cnt <= '0;
    else if (EN) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/time_keeper.sv
// time_keeper: free-running 24 h BCD HH:MM counter with validated load
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_PER_MIN = 60
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         EN,
  input  logic         LD,
  input  logic [3:0]   Dig0,
  input  logic [3:0]   Dig1,
  input  logic [3:0]   Dig2,
  input  logic [3:0]   Dig3,
  output logic [3:0]   DigN0,
  output logic [3:0]   DigN1,
  output logic [3:0]   DigN2,
  output logic [3:0]   DigN3,
  output logic         sec_tick,
  output logic         min_pulse,
  output logic         load_err
);
  localparam int SW = SEC_PER_MIN > 1 ? $clog2(SEC_PER_MIN) : 1;
  logic tick, ld_ok, roll;
  logic [SW-1:0] sec;
  hhmm_t now, ld_val;
  assign ld_val = {Dig3, Dig2, Dig1, Dig0};
  assign ld_ok = LD && load_ok(ld_val);
  assign roll = tick && sec == SW'(SEC_PER_MIN - 1);
  assign {DigN3, DigN2, DigN1, DigN0} = now;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk),
    .reset_(reset_),
    .EN(EN),
    .clr(ld_ok),
    .tick(tick)
  );
  // a valid load wins over a coinciding tick/rollover and restarts the minute
  always_ff @(posedge clk) begin
    if (reset_) begin
      now <= {4{DIG_RST}};
      sec <= '0;
      sec_tick <= 1'b0;
      min_pulse <= 1'b0;
      load_err <= 1'b0;
    end else begin
      now <= ld_ok ? ld_val : roll ? bcd_inc(now) : now;
      sec <= ld_ok || roll ? '0 : tick ? sec + 1'b1 : sec;
      sec_tick <= tick && !ld_ok;
      min_pulse <= roll && !ld_ok;
      load_err <= LD && !ld_ok;
    end
  end
endmodule
